// File: rtl/score_glyph_plotter.sv
// Rasterises a two-digit glyph map into a fixed on-screen box, one pixel per clock.
// Every box pixel is written in FG or BG colour, so the previous score is overwritten in place.
module score_glyph_plotter #(
  parameter logic [7:0] X0          = 8'd130,
  parameter logic [6:0] Y0          = 7'd2,
  parameter int         SCALE       = 2,
  parameter int         GAP         = 1,
  parameter logic [2:0] FG_COLOR    = 3'b111,
  parameter logic [2:0] BG_COLOR    = 3'b000,
  parameter bit         SUPPRESS_LZ = 1'b1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        draw,
  input  logic [29:0] map,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  color,
  output logic        plot,
  output logic        finish_drawing
);

  // state | meaning
  // IDLE  | waiting for draw; map is snapshotted on the accepting edge
  // PLOT  | emitting one box pixel per cycle in raster order
  // DONE  | box written; finish_drawing held until draw drops

  localparam int          NC         = 6 + GAP;
  localparam logic [1:0]  SC_LAST    = 2'(SCALE - 1);
  localparam logic [3:0]  GC_LAST    = 4'(NC - 1);
  localparam logic [2:0]  GR_LAST    = 3'd4;
  localparam logic [3:0]  ONES_C0    = 4'(3 + GAP);
  localparam logic [14:0] ZERO_GLYPH = 15'b111101101101111;

  typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

  state_t      state;
  logic [14:0] snap_tens, snap_ones;
  logic [1:0]  sx, sy;
  logic [3:0]  gc;
  logic [2:0]  gr;

  logic [1:0]  nsx, nsy;
  logic [3:0]  ngc;
  logic [2:0]  ngr;
  logic [7:0]  nx;
  logic [6:0]  ny;
  logic        last_px;
  logic [14:0] tens_in;
  logic [2:0]  color_first, color_next;

  function automatic logic cell_lit(input logic [14:0] t, input logic [14:0] o,
                                    input logic [3:0] c, input logic [2:0] r);
    logic [4:0] base;
    logic [4:0] idx;
    base     = {2'b00, r} * 5'd3;
    cell_lit = 1'b0;
    if (c < 4'd3) idx = base + {1'b0, c};
    else          idx = base + {1'b0, c - ONES_C0};
    if (idx < 5'd15) begin
      if (c < 4'd3)          cell_lit = t[idx[3:0]];
      else if (c >= ONES_C0) cell_lit = o[idx[3:0]];
    end
  endfunction

  // sx/sy are down-counters over the SCALE repeats of each glyph cell
  always_comb begin
    nsx = sx - 2'd1;
    nsy = sy;
    ngc = gc;
    ngr = gr;
    nx  = x + 8'd1;
    ny  = y;
    if (sx == 2'd0) begin
      nsx = SC_LAST;
      if (gc != GC_LAST) begin
        ngc = gc + 4'd1;
      end else begin
        ngc = 4'd0;
        nx  = X0;
        ny  = y + 7'd1;
        if (sy == 2'd0) begin
          nsy = SC_LAST;
          ngr = gr + 3'd1;
        end else begin
          nsy = sy - 2'd1;
        end
      end
    end
    last_px = (sx == 2'd0) && (gc == GC_LAST) && (sy == 2'd0) && (gr == GR_LAST);
  end

  always_comb begin
    tens_in = (SUPPRESS_LZ && (map[29:15] == ZERO_GLYPH)) ? 15'd0 : map[29:15];
    color_first = cell_lit(tens_in, map[14:0], 4'd0, 3'd0) ? FG_COLOR : BG_COLOR;
    color_next  = cell_lit(snap_tens, snap_ones, ngc, ngr) ? FG_COLOR : BG_COLOR;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      x              <= 8'd0;
      y              <= 7'd0;
      color          <= 3'd0;
      plot           <= 1'b0;
      finish_drawing <= 1'b0;
      snap_tens      <= 15'd0;
      snap_ones      <= 15'd0;
      sx             <= 2'd0;
      sy             <= 2'd0;
      gc             <= 4'd0;
      gr             <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          plot           <= 1'b0;
          finish_drawing <= 1'b0;
          if (draw) begin
            state     <= PLOT;
            snap_tens <= tens_in;
            snap_ones <= map[14:0];
            x         <= X0;
            y         <= Y0;
            color     <= color_first;
            plot      <= 1'b1;
            sx        <= SC_LAST;
            sy        <= SC_LAST;
            gc        <= 4'd0;
            gr        <= 3'd0;
          end
        end
        PLOT: begin
          if (!draw) begin
            state <= IDLE;
            plot  <= 1'b0;
          end else if (last_px) begin
            state          <= DONE;
            plot           <= 1'b0;
            finish_drawing <= 1'b1;
          end else begin
            sx    <= nsx;
            sy    <= nsy;
            gc    <= ngc;
            gr    <= ngr;
            x     <= nx;
            y     <= ny;
            color <= color_next;
          end
        end
        DONE: begin
          if (!draw) begin
            state          <= IDLE;
            finish_drawing <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_glyph_plotter.sv
// Bench for score_glyph_plotter: directed and randomised draws checked against a pixel model
// that derives each colour from the glyph map by plain division of box coordinates.
module tb_score_glyph_plotter;
  localparam int W = 14, H = 10, X0 = 130, Y0 = 2, SCALE = 2, GAP = 1;

  logic        clock = 1'b0;
  logic        resetn;
  logic        draw;
  logic [29:0] map;
  logic [7:0]  x_a, x_b;
  logic [6:0]  y_a, y_b;
  logic [2:0]  color_a, color_b;
  logic        plot_a, plot_b, fin_a, fin_b;

  int checks = 0;
  int errors = 0;
  logic [14:0] font [10];
  int pix_a [W*H];
  int pix_b [W*H];

  score_glyph_plotter #(.SUPPRESS_LZ(1'b1)) dut (
    .clock(clock), .resetn(resetn), .draw(draw), .map(map),
    .x(x_a), .y(y_a), .color(color_a), .plot(plot_a), .finish_drawing(fin_a));

  score_glyph_plotter #(.SUPPRESS_LZ(1'b0)) dut_nl (
    .clock(clock), .resetn(resetn), .draw(draw), .map(map),
    .x(x_b), .y(y_b), .color(color_b), .plot(plot_b), .finish_drawing(fin_b));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rv(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // rows written left-to-right as seen on screen; bit c of each row is column c
  function automatic logic [14:0] mkg(input logic [2:0] r0, input logic [2:0] r1,
                                      input logic [2:0] r2, input logic [2:0] r3,
                                      input logic [2:0] r4);
    return {rv(r4), rv(r3), rv(r2), rv(r1), rv(r0)};
  endfunction

  function automatic int exp_color(input logic [29:0] m, input bit sup, input int px, input int py);
    logic [14:0] tens, ones;
    int gcol, grow;
    bit lit;
    tens = m[29:15];
    ones = m[14:0];
    if (sup && tens == 15'b111101101101111) tens = '0;
    gcol = px / SCALE;
    grow = py / SCALE;
    lit  = 1'b0;
    if (gcol < 3)             lit = tens[3*grow + gcol];
    else if (gcol >= 3 + GAP) lit = ones[3*grow + gcol - 3 - GAP];
    return lit ? 7 : 0;
  endfunction

  task automatic plot_run(input logic [29:0] m, input int abort_at, input int change_at,
                          input int reset_at, input logic [29:0] m2);
    int px, py;
    map  = m;
    draw = 1'b1;
    for (int i = 0; i < W*H; i++) begin
      @(negedge clock);
      px = i % W;
      py = i / W;
      chk("plot_a", plot_a, 1);
      chk("x_a", x_a, X0 + px);
      chk("y_a", y_a, Y0 + py);
      chk("color_a", color_a, exp_color(m, 1'b1, px, py));
      chk("fin_a", fin_a, 0);
      chk("plot_b", plot_b, 1);
      chk("x_b", x_b, X0 + px);
      chk("color_b", color_b, exp_color(m, 1'b0, px, py));
      pix_a[i] = color_a;
      pix_b[i] = color_b;
      if (i == change_at) map = m2;
      if (i == reset_at) begin
        #1 resetn = 1'b0;
        draw = 1'b0;
        #1;
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_color", color_a, 0);
        chk("rst_plot", plot_a, 0);
        chk("rst_fin", fin_a, 0);
        chk("rst_plot_b", plot_b, 0);
        @(negedge clock);
        resetn = 1'b1;
        return;
      end
      if (i == abort_at) begin
        draw = 1'b0;
        @(negedge clock);
        chk("abort_plot_a", plot_a, 0);
        chk("abort_fin_a", fin_a, 0);
        chk("abort_plot_b", plot_b, 0);
        return;
      end
    end
    @(negedge clock);
    chk("end_plot_a", plot_a, 0);
    chk("end_fin_a", fin_a, 1);
    chk("end_fin_b", fin_b, 1);
    chk("end_x_a", x_a, X0 + W - 1);
    chk("end_y_a", y_a, Y0 + H - 1);
    chk("end_color_a", color_a, exp_color(m, 1'b1, W - 1, H - 1));
  endtask

  task automatic release_draw();
    draw = 1'b0;
    @(negedge clock);
    chk("rel_fin_a", fin_a, 0);
    chk("rel_fin_b", fin_b, 0);
    chk("rel_plot_a", plot_a, 0);
  endtask

  initial begin
    logic [29:0] m;
    int ab;
    font[0] = mkg(3'b111, 3'b101, 3'b101, 3'b101, 3'b111);
    font[1] = mkg(3'b010, 3'b110, 3'b010, 3'b010, 3'b111);
    font[2] = mkg(3'b111, 3'b001, 3'b111, 3'b100, 3'b111);
    font[3] = mkg(3'b111, 3'b001, 3'b111, 3'b001, 3'b111);
    font[4] = mkg(3'b101, 3'b101, 3'b111, 3'b001, 3'b001);
    font[5] = mkg(3'b111, 3'b100, 3'b111, 3'b001, 3'b111);
    font[6] = mkg(3'b111, 3'b100, 3'b111, 3'b101, 3'b111);
    font[7] = mkg(3'b111, 3'b001, 3'b001, 3'b001, 3'b001);
    font[8] = mkg(3'b111, 3'b101, 3'b111, 3'b101, 3'b111);
    font[9] = mkg(3'b111, 3'b101, 3'b111, 3'b001, 3'b111);

    resetn = 1'b1;
    draw   = 1'b0;
    map    = '0;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clock);
    chk("init_x", x_a, 0);
    chk("init_y", y_a, 0);
    chk("init_color", color_a, 0);
    chk("init_plot", plot_a, 0);
    chk("init_fin", fin_a, 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_plot", plot_a, 0);

    // digits 4,2 with fixed probe pixels, then handshake hold and replot
    plot_run({font[4], font[2]}, -1, -1, -1, '0);
    chk("p130_2", pix_a[0], 7);
    chk("p132_2", pix_a[2], 0);
    chk("p138_2", pix_a[8], 7);
    chk("p138_4", pix_a[2*W + 8], 0);
    chk("p142_4", pix_a[2*W + 12], 7);
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      chk("hold_fin", fin_a, 1);
      chk("hold_plot", plot_a, 0);
      chk("hold_x", x_a, X0 + W - 1);
    end
    release_draw();
    plot_run({font[4], font[2]}, -1, -1, -1, '0);
    release_draw();

    // leading-zero suppression
    plot_run({font[0], font[1]}, -1, -1, -1, '0);
    for (int i = 0; i < W*H; i++)
      if ((i % W) < 6) chk("lz_tens", pix_a[i], 0);
    chk("nolz_p130_2", pix_b[0], 7);
    release_draw();

    // map snapshot: map changed mid-plot is ignored
    plot_run({font[3], font[5]}, -1, 20, -1, {font[9], font[9]});
    release_draw();

    // abort and restart
    plot_run({font[7], font[8]}, 50, -1, -1, '0);
    repeat (3) begin
      @(negedge clock);
      chk("post_abort_fin", fin_a, 0);
    end
    plot_run({font[6], font[1]}, -1, -1, -1, '0);
    release_draw();

    // async reset mid-plot
    plot_run({font[9], font[3]}, -1, -1, 60, '0);
    @(negedge clock);
    chk("post_rst_plot", plot_a, 0);
    chk("post_rst_fin", fin_a, 0);

    // randomised maps, some aborted
    for (int k = 0; k < 6; k++) begin
      if (k[0]) m = {font[$urandom_range(9)], font[$urandom_range(9)]};
      else      m = 30'($urandom);
      ab = ($urandom_range(2) == 0) ? int'($urandom_range(W*H - 1)) : -1;
      plot_run(m, ab, -1, -1, '0);
      if (ab < 0) release_draw();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
